regfile_mp: RTL

Parametrised multi-port integer register file for the RV32IC core, succeeding the single-read-port regfile. Provides NUM_READ synchronous read ports and one write port, with per-port write-to-read bypass, an optional hardwired-zero register x0, per-port read enables, and a post-reset clear sweep that zeroes every entry. It sits between the ID stage (source operand reads) and the WB stage (destination writes).

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_rd_port.sv | 55 +++++
 rtl/regfile_mp.sv | 100 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the multi-port integer register file.
// Also imported by the decode stage so operand widths stay in sync.
package regfile_pkg;

    localparam int unsigned DefAddrWidth = 5;
    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefRamSize   = 32;

    typedef enum logic [0:0] {
        StInit,
        StRun
    } rf_state_e;

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: range check, hardwired-zero check, write bypass
// and hold-when-disabled, all resolved into a single output register.
module regfile_rd_port #(
    parameter int unsigned ADDR_WIDTH = regfile_pkg::DefAddrWidth,
    parameter int unsigned DATA_WIDTH = regfile_pkg::DefDataWidth,
    parameter int unsigned RAM_SIZE   = regfile_pkg::DefRamSize,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [DATA_WIDTH-1:0] entry,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  in_range;
    logic                  is_zero;
    logic                  bypass_hit;

    assign in_range   = 32'(read_addr) < RAM_SIZE;
    assign is_zero    = ZERO_REG && (read_addr == '0);
    assign bypass_hit = we && (write_addr == read_addr);

    // Out-of-range and x0 reads are resolved before the bypass so a dropped
    // write can never leak through to the read data.
    always_comb begin
        dout_d = dout_q;
        if (run && re) begin
            if (!in_range || is_zero) begin
                dout_d = '0;
            end else if (bypass_hit) begin
                dout_d = din;
            end else begin
                dout_d = entry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_READ registered read ports, one write port,
// and a post-reset sweep that zeroes every entry before ready is raised.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned RAM_SIZE   = DefRamSize,
    parameter int unsigned NUM_READ   = 2,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we,
    input  logic [ADDR_WIDTH-1:0]          write_addr,
    input  logic [DATA_WIDTH-1:0]          din,
    input  logic [NUM_READ-1:0]            re,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] dout,
    output logic                           ready
);

    localparam int unsigned CntWidth = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;

    rf_state_e             state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [RAM_SIZE];
    logic                  run;
    logic                  wr_addr_ok;
    logic                  wr_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StInit: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntWidth'(RAM_SIZE - 1)) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StInit;
        endcase
    end

    assign run        = (state_q == StRun);
    assign ready      = run;
    assign wr_addr_ok = (32'(write_addr) < RAM_SIZE) && !(ZERO_REG && (write_addr == '0));
    assign wr_en      = run && we && wr_addr_ok;

    // Array has no reset: contents are defined only by the clear sweep.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == StInit) begin
                mem_q[cnt_q] <= '0;
            end else if (wr_en) begin
                mem_q[write_addr] <= din;
            end
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] entry;

        assign ra    = read_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign entry = mem_q[ra];

        regfile_rd_port #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .RAM_SIZE   (RAM_SIZE),
            .ZERO_REG   (ZERO_REG)
        ) u_rd_port (
            .clk        (clk),
            .rst        (rst),
            .run        (run),
            .re         (re[p]),
            .read_addr  (ra),
            .we         (we),
            .write_addr (write_addr),
            .din        (din),
            .entry      (entry),
            .dout       (dout[p*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule
